// File: rtl/uart_rx_axis_packetizer.sv
// UART byte strobes -> FIFO -> AXI4-Stream master; packet mode (tlast on idle) under UART_AXIS_TLAST_EN.
// One-cycle push-to-head latency; upstream cannot stall, so full-FIFO bytes are dropped and flagged.
module uart_rx_axis_packetizer #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          rx_data,
    input  logic                          rx_valid,
    output logic [DATA_BITS-1:0]          m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 count_nz;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 overflow_q;

    assign count_nz = (count != '0);
    assign pop      = m_axis_tvalid & m_axis_tready;
    assign push     = rx_valid & ((count != FULL_CNT) | pop);
    assign drop     = rx_valid & (count == FULL_CNT) & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (overflow_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow     = overflow_q;
    assign fifo_count   = count;
    assign m_axis_tdata = count_nz ? mem[rd_ptr] : '0;

`ifdef UART_AXIS_TLAST_EN
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);
    localparam logic [IW-1:0] IDLE_PRE = IW'(IDLE_TIMEOUT - 1);

    logic [IW-1:0]         idle_cnt;
    logic [FIFO_DEPTH-1:0] last_flag;
    logic [AW-1:0]         newest_ptr;
    logic                  mark;
    logic                  head_last;

    assign newest_ptr = wr_ptr - AW'(1);
    // No rx_valid in a marking cycle, so marking never collides with a push.
    assign mark       = ~rx_valid & (idle_cnt == IDLE_PRE) & count_nz;
    assign head_last  = last_flag[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (rx_valid) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_flag <= '0;
        end else begin
            if (push) begin
                last_flag[wr_ptr] <= 1'b0;
            end
            if (mark) begin
                last_flag[newest_ptr] <= 1'b1;
            end
        end
    end

    // A lone newest byte waits until it is either closed or followed.
    assign m_axis_tvalid = (count >= CW'(2)) | ((count == CW'(1)) & head_last);
    assign m_axis_tlast  = count_nz & head_last;
`else
    assign m_axis_tvalid = count_nz;
    assign m_axis_tlast  = 1'b0;
`endif

endmodule
